// File: rtl/fetch_queue.sv
// Instruction prefetch FIFO between fetch (INST_MEM/pc_adder) and the FD stage.
// Holds {instr, PC+4} pairs with valid/ready on both sides; flushed on taken branch/jump.
module fetch_queue #(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_instr,
  input  logic [DATA_W-1:0] push_pc4,
  output logic              push_ready,
  input  logic              pop_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_instr,
  output logic [DATA_W-1:0] pop_pc4,
  input  logic              flush,
  output logic [PTR_W:0]    count,
  output logic              overflow_err
);

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] instrMem [DEPTH];
  logic [DATA_W-1:0] pc4Mem   [DEPTH];
  logic [PTR_W-1:0]  wrPtr;
  logic [PTR_W-1:0]  rdPtr;
  logic              pushFire;
  logic              popFire;

  // Full/empty come only from count; pointers wrap naturally since DEPTH = 2**PTR_W.
  assign push_ready = (count != FULL_COUNT);
  assign pop_valid  = (count != '0);
  assign pushFire   = push_valid & push_ready;
  assign popFire    = pop_ready & pop_valid;
  assign pop_instr  = pop_valid ? instrMem[rdPtr] : '0;
  assign pop_pc4    = pop_valid ? pc4Mem[rdPtr]   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushFire) wrPtr <= wrPtr + PTR_W'(1);
      if (popFire)  rdPtr <= rdPtr + PTR_W'(1);
      if (pushFire && !popFire)
        count <= count + (PTR_W+1)'(1);
      else if (popFire && !pushFire)
        count <= count - (PTR_W+1)'(1);
    end
  end

  // Storage needs no reset; a flush discards the concurrent push as well.
  always_ff @(posedge clk) begin
    if (pushFire && !flush) begin
      instrMem[wrPtr] <= push_instr;
      pc4Mem[wrPtr]   <= push_pc4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow_err <= 1'b0;
    else if (push_valid && !push_ready)
      overflow_err <= 1'b1;
  end

endmodule
